av_arbiter_2to1: RTL
====================

# av_arbiter_2to1

Two-master, one-slave Avalon-MM arbiter placed directly upstream of the word-addressed on-chip RAM. It merges two requesters, the instruction fetch port (M0) and the data port (M1), onto the single RAM slave port. Grants are round-robin with zero added request latency. Because the RAM has fixed read latency and no readdatavalid, the block tracks accepted reads in a tag pipeline and returns each word, with a per-master valid pulse, to the master that issued it.

## Interface
Parameters:
- ADDR_W, 30: word-address width, identical on all ports.
- READ_LATENCY, 1: cycles from the slave accepting a read to valid i_S_ReadData. Legal range 1–4.

Ports:
- i_Clk  in  1  single clock. All state changes on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Mx_Addr  in  ADDR_W  master x address, x∈{0,1}.
- i_Mx_ByteEn  in  4  master x byte enables.
- i_Mx_Read / i_Mx_Write  in  1  master x read/write request.
- i_Mx_WriteData  in  32  master x write data.
- o_Mx_ReadData  out  32  returned read data; 0 when o_Mx_ReadDataValid=0.
- o_Mx_ReadDataValid  out  1  one-cycle pulse per completed read.
- o_Mx_WaitRequest  out  1  stall to master x.
- o_S_Addr, o_S_ByteEn, o_S_Read, o_S_Write, o_S_WriteData  out  ADDR_W/4/1/1/32  to RAM.
- i_S_ReadData  in  32  RAM read data.
- i_S_WaitRequest  in  1  RAM stall (currently always 0; must be honoured).

## Operation
- req_x = i_Mx_Read | i_Mx_Write.
- Grant is combinational from req_0, req_1 and the register last_grant:
  - only one master requesting: that master is granted;
  - both requesting: grant = ~last_grant;
  - none requesting: no grant, and o_S_Read = o_S_Write = 0.
- Slave outputs are muxed from the granted master. Addr/ByteEn/WriteData are don't-care without a grant but must be driven, defaulting to M0's values.
- Wait requests:
  - o_Mx_WaitRequest = i_S_WaitRequest when x is granted;
  - 1 when x requests but is not granted;
  - 0 when x is idle.
- Acceptance: a transfer is accepted on an edge where a grant exists and i_S_WaitRequest=0.
  - On acceptance, last_grant <= granted id.
  - last_grant never changes otherwise, so a stalled grant stays stable while masters hold their requests (Avalon hold rule).
- Read and write asserted together by one master are forwarded unchanged. The pair counts as a read for tagging.
- Tag pipeline: READ_LATENCY stages of {valid, id}.
  - On acceptance of a read, stage0 <= {1, id}; otherwise stage0 <= {0, x}. Each stage then shifts one per cycle.
  - Last stage valid with id=x: o_Mx_ReadDataValid=1 and o_Mx_ReadData=i_S_ReadData (combinational).
  - Every other master/cycle: valid=0, data=0.
- Writes produce no response.
- Back-to-back accepted reads, one per cycle, are fully supported; no outstanding-read limit.

## Timing
- Arbitration adds zero cycles. The master→slave path is combinational, and a request can be accepted in the cycle it is first asserted.
- Read accepted at edge E: data and valid appear in the cycle after edge E+READ_LATENCY−1 (for READ_LATENCY=1, the cycle immediately after E).
- Continuous contention alternates M0, M1, M0, …, one transfer per cycle. A lone requester gets every cycle.
- Reset values:
  - last_grant=1, so M0 wins the first tie;
  - all tag stages invalid;
  - o_Mx_ReadDataValid=0 and o_Mx_ReadData=0.
- Reset mid-operation: in-flight tags are discarded and no valid pulse follows reset.
- While i_Reset=1, slave outputs still follow the combinational grant. Masters must hold requests low during reset.
- A request dropped before acceptance (Avalon violation) is undefined; the block must not deadlock.

## Structure
- Shared package av_bus_pkg holds:
  - MASTER_ID_W=1;
  - rd_tag_t {valid, id};
  - constants M0_ID=0 and M1_ID=1.
- Sub-module av_rdtag_pipe: parameterised READ_LATENCY shift register of rd_tag_t with synchronous clear.
- Arbiter logic and muxing stay in the top module.

## Test plan
- Single read: M0 reads addr 5 after RAM[5]=0xDEADBEEF was written via M1 → M1 write accepted the cycle it is asserted; M0 sees valid=1 with 0xDEADBEEF one cycle after acceptance; o_M1_ReadDataValid stays 0.
- Contention: both masters hold reads (M0 addr 1, M1 addr 2) from reset → M0 granted first, M1 waited one cycle; valids return in order M0, then M1, with the correct data.
- Sustained contention: both masters stream 8 reads each → grants strictly alternate; 16 valid pulses total, none lost or misrouted.
- Byte-enable pass-through: M1 writes 0x11223344 with ByteEn=4'b0101 over 0xFFFFFFFF, then reads back → 0xFF22FF44.
- Slave stall: force i_S_WaitRequest=1 for 3 cycles during an M1 read with M0 also requesting → grant stays on M1; M0 stays waited; M1 is served on release, then M0.
- Reset mid-flight: assert i_Reset the cycle after an accepted read → no o_Mx_ReadDataValid pulse; next tie is granted to M0.

Source files
------------

// File: rtl/av_bus_pkg.sv
// Shared Avalon-MM bus types: master ids and the read-return tag that follows each accepted read.
// Pure declarations, no timing or flow control of its own.
package av_bus_pkg;
  localparam int MASTER_ID_W = 1;
  localparam int TAG_W       = 1 + MASTER_ID_W;

  localparam logic [MASTER_ID_W-1:0] M0_ID = 1'b0;
  localparam logic [MASTER_ID_W-1:0] M1_ID = 1'b1;

  typedef struct packed {
    logic                   valid;
    logic [MASTER_ID_W-1:0] id;
  } rd_tag_t;
endpackage

// File: rtl/av_rdtag_pipe.sv
// DEPTH-stage shift register of read tags, mirroring the RAM's fixed read latency.
// Latency DEPTH cycles; never stalls, one tag in and out per cycle; i_Clear empties every stage.
module av_rdtag_pipe
  import av_bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_Clear,
  input  logic [TAG_W-1:0] i_Tag,
  output logic [TAG_W-1:0] o_Tag
);

  rd_tag_t r_Stage [DEPTH];

  always_ff @(posedge i_Clk) begin
    if (i_Clear) begin
      for (int i = 0; i < DEPTH; i++) r_Stage[i] <= '0;
    end else begin
      r_Stage[0] <= rd_tag_t'(i_Tag);
      for (int i = 1; i < DEPTH; i++) r_Stage[i] <= r_Stage[i-1];
    end
  end

  assign o_Tag = r_Stage[DEPTH-1];

endmodule

// File: rtl/av_arbiter_2to1.sv
// Round-robin 2:1 Avalon-MM arbiter in front of a fixed-latency RAM; zero-cycle combinational grant.
// Read data returns READ_LATENCY cycles after acceptance; slave stall is passed to the granted master only.
module av_arbiter_2to1
  import av_bus_pkg::*;
#(
  parameter int ADDR_W       = 30,
  parameter int READ_LATENCY = 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [ADDR_W-1:0] i_M0_Addr,
  input  logic [3:0]        i_M0_ByteEn,
  input  logic              i_M0_Read,
  input  logic              i_M0_Write,
  input  logic [31:0]       i_M0_WriteData,
  output logic [31:0]       o_M0_ReadData,
  output logic              o_M0_ReadDataValid,
  output logic              o_M0_WaitRequest,
  input  logic [ADDR_W-1:0] i_M1_Addr,
  input  logic [3:0]        i_M1_ByteEn,
  input  logic              i_M1_Read,
  input  logic              i_M1_Write,
  input  logic [31:0]       i_M1_WriteData,
  output logic [31:0]       o_M1_ReadData,
  output logic              o_M1_ReadDataValid,
  output logic              o_M1_WaitRequest,
  output logic [ADDR_W-1:0] o_S_Addr,
  output logic [3:0]        o_S_ByteEn,
  output logic              o_S_Read,
  output logic              o_S_Write,
  output logic [31:0]       o_S_WriteData,
  input  logic [31:0]       i_S_ReadData,
  input  logic              i_S_WaitRequest
);

  logic [MASTER_ID_W-1:0] r_LastGrant;
  logic                   w_Req0;
  logic                   w_Req1;
  logic                   w_GrantVld;
  logic [MASTER_ID_W-1:0] w_GrantId;
  logic                   w_SelM1;
  logic                   w_Accept;
  rd_tag_t                w_TagIn;
  logic [TAG_W-1:0]       w_TagOutBits;
  rd_tag_t                w_TagOut;
  logic                   w_Rsp0;
  logic                   w_Rsp1;

  assign w_Req0 = i_M0_Read | i_M0_Write;
  assign w_Req1 = i_M1_Read | i_M1_Write;

  always_comb begin
    w_GrantVld = w_Req0 | w_Req1;
    w_GrantId  = M0_ID;
    if (w_Req0 && w_Req1) w_GrantId = ~r_LastGrant;
    else if (w_Req1)      w_GrantId = M1_ID;
  end

  assign w_SelM1 = w_GrantVld && (w_GrantId == M1_ID);

  // Addr/ByteEn/WriteData fall back to M0 when nobody is granted.
  assign o_S_Addr      = w_SelM1 ? i_M1_Addr      : i_M0_Addr;
  assign o_S_ByteEn    = w_SelM1 ? i_M1_ByteEn    : i_M0_ByteEn;
  assign o_S_WriteData = w_SelM1 ? i_M1_WriteData : i_M0_WriteData;
  assign o_S_Read      = w_GrantVld && (w_SelM1 ? i_M1_Read  : i_M0_Read);
  assign o_S_Write     = w_GrantVld && (w_SelM1 ? i_M1_Write : i_M0_Write);

  assign o_M0_WaitRequest = w_Req0 && (w_SelM1 ? 1'b1 : i_S_WaitRequest);
  assign o_M1_WaitRequest = w_Req1 && (w_SelM1 ? i_S_WaitRequest : 1'b1);

  assign w_Accept = w_GrantVld && !i_S_WaitRequest;

  // last_grant moves only on acceptance, so a stalled grant holds steady.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)       r_LastGrant <= M1_ID;
    else if (w_Accept) r_LastGrant <= w_GrantId;
  end

  assign w_TagIn.valid = w_Accept && o_S_Read;
  assign w_TagIn.id    = w_GrantId;

  av_rdtag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rdtag_pipe (
    .i_Clk   (i_Clk),
    .i_Clear (i_Reset),
    .i_Tag   (w_TagIn),
    .o_Tag   (w_TagOutBits)
  );

  assign w_TagOut = rd_tag_t'(w_TagOutBits);

  // Gated by reset so a tag still in the last stage when reset rises never surfaces.
  assign w_Rsp0 = w_TagOut.valid && (w_TagOut.id == M0_ID) && !i_Reset;
  assign w_Rsp1 = w_TagOut.valid && (w_TagOut.id == M1_ID) && !i_Reset;

  assign o_M0_ReadDataValid = w_Rsp0;
  assign o_M1_ReadDataValid = w_Rsp1;
  assign o_M0_ReadData      = w_Rsp0 ? i_S_ReadData : 32'd0;
  assign o_M1_ReadData      = w_Rsp1 ? i_S_ReadData : 32'd0;

endmodule
